aes_ctr_xor_join: RTL

//  Datapath join of AES-CTR: pairs each plaintext AXIS beat with one keystream block from the
//  AES core, XORs them, zeroes bytes not covered by tkeep, and buffers the result in a 2-entry

---
 rtl/aes_ctr_xor_join_pkg.sv | 32 +++
 rtl/aes_ctr_xor_join_skid_fifo2.sv | 66 ++++++
 rtl/aes_ctr_xor_join.sv | 119 +++++++++++
 3 files changed

// File: rtl/aes_ctr_xor_join_pkg.sv
// Shared widths, FIFO occupancy encoding and tkeep helpers for the AES-CTR datapath join.
package aes_ctr_xor_join_pkg;

    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned KEEP_W_DEF = DATA_W_DEF / 8;
    localparam int unsigned CNT_W_DEF  = 16;
    // Helpers work on a fixed maximum width; callers zero-extend and truncate.
    localparam int unsigned MAX_KEEP_W = 64;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    function automatic logic [MAX_KEEP_W*8-1:0] keep_to_mask(input logic [MAX_KEEP_W-1:0] keep);
        logic [MAX_KEEP_W*8-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MAX_KEEP_W; i++) begin
            mask[8*i +: 8] = {8{keep[i]}};
        end
        return mask;
    endfunction

    // True when keep is a non-empty run of ones starting at bit 0.
    function automatic logic keep_is_prefix(input logic [MAX_KEEP_W-1:0] keep);
        logic [MAX_KEEP_W-1:0] one;
        one = {{(MAX_KEEP_W-1){1'b0}}, 1'b1};
        return (keep != '0) && ((keep & (keep + one)) == '0);
    endfunction

endpackage

// File: rtl/aes_ctr_xor_join_skid_fifo2.sv
// Two-entry valid/ready buffer; the head register drives the output and holds its value when empty.
module axis_skid_fifo2
    import aes_ctr_xor_join_pkg::*;
#(
    parameter int unsigned W = 145
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output occ_e         occ
);

    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    occ_e         occ_q;
    logic         push;
    logic         pop;

    assign in_ready  = (occ_q != OCC_FULL);
    assign out_valid = (occ_q != OCC_EMPTY);
    assign out_data  = head_q;
    assign occ       = occ_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        head_q <= in_data;
                        occ_q  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({push, pop})
                        2'b11: head_q <= in_data;
                        2'b10: begin
                            tail_q <= in_data;
                            occ_q  <= OCC_FULL;
                        end
                        2'b01: occ_q <= OCC_EMPTY;
                        default: ;
                    endcase
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_q <= tail_q;
                        occ_q  <= OCC_ONE;
                    end
                end
                default: occ_q <= OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/aes_ctr_xor_join.sv
// AES-CTR join: pairs plaintext with keystream, XORs and byte-masks, buffers the result,
// counts beats per packet and flags malformed tkeep.
module aes_ctr_xor_join
    import aes_ctr_xor_join_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned KEEP_W = DATA_W / 8,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic [DATA_W-1:0] ks_data,
    input  logic              ks_valid,
    output logic              ks_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  beat_cnt,
    output logic              keep_err,
    input  logic              err_clr
);

    localparam int unsigned FW = DATA_W + KEEP_W + 1;

    logic                  space_q;
    logic                  space_d;
    logic                  join_fire;
    logic                  fifo_in_ready;
    logic                  pop;
    logic                  bad_keep;
    logic [MAX_KEEP_W-1:0] keep_ext;
    logic [DATA_W-1:0]     byte_mask;
    logic [DATA_W-1:0]     cipher;
    logic [FW-1:0]         fifo_in;
    logic [FW-1:0]         fifo_out;
    occ_e                  occ;

    assign s_tready  = ks_valid & space_q;
    assign ks_ready  = s_tvalid & space_q;
    assign join_fire = s_tvalid & ks_valid & space_q & fifo_in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        keep_ext               = '0;
        keep_ext[KEEP_W-1:0]   = s_tkeep;
        byte_mask              = DATA_W'(keep_to_mask(keep_ext));
        cipher                 = (s_tdata ^ ks_data) & byte_mask;
        bad_keep               = (s_tkeep == '0)
                               || (!s_tlast && (s_tkeep != '1))
                               || (s_tlast && !keep_is_prefix(keep_ext));
    end

    // space is registered from next-cycle occupancy so it never lags a fill.
    always_comb begin
        case (occ)
            OCC_FULL: space_d = pop;
            OCC_ONE:  space_d = !(join_fire && !pop);
            default:  space_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            space_q <= 1'b0;
        end else begin
            space_q <= space_d;
        end
    end

    assign fifo_in = {cipher, s_tkeep, s_tlast};

    axis_skid_fifo2 #(
        .W (FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (fifo_in),
        .in_valid  (join_fire),
        .in_ready  (fifo_in_ready),
        .out_data  (fifo_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occ       (occ)
    );

    assign out_data = fifo_out[FW-1 -: DATA_W];
    assign out_keep = fifo_out[KEEP_W:1];
    assign out_last = fifo_out[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (pop) begin
            if (out_last) begin
                beat_cnt <= '0;
            end else if (beat_cnt != '1) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keep_err <= 1'b0;
        end else if (join_fire && bad_keep) begin
            keep_err <= 1'b1;
        end else if (err_clr) begin
            keep_err <= 1'b0;
        end
    end

endmodule
